// File: rtl/vga_pattern_scheduler.sv
// Frame-synchronous test-pattern selector for the VGA datapath.
// Advances on button or auto timer only at frame ends, with optional black frame.
module vga_pattern_scheduler #(
  parameter int NUM_PATTERNS = 4,
  parameter int AUTO_FRAMES  = 120,
  parameter int H_ACT        = 640,
  parameter int V_ACT        = 480,
  parameter int BLANK_EN     = 1
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [9:0]                      x_pixel,
  input  logic [9:0]                      y_pixel,
  input  logic                            DE,
  input  logic                            btn_next,
  input  logic                            btn_auto,
  input  logic [12*NUM_PATTERNS-1:0]      rgb_src_bus,
  output logic [3:0]                      red_port,
  output logic [3:0]                      green_port,
  output logic [3:0]                      blue_port,
  output logic                            de_out,
  output logic [$clog2(NUM_PATTERNS)-1:0] pattern_sel,
  output logic                            auto_mode,
  output logic [15:0]                     frame_cnt
);

  localparam int SW = $clog2(NUM_PATTERNS);
  localparam int CW = $clog2(AUTO_FRAMES);
  localparam logic [9:0]    X_LAST   = 10'(H_ACT - 1);
  localparam logic [9:0]    Y_LAST   = 10'(V_ACT - 1);
  localparam logic [SW-1:0] SEL_LAST = SW'(NUM_PATTERNS - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(AUTO_FRAMES - 1);

  typedef enum logic {
    RUN   = 1'b0,
    BLANK = 1'b1
  } state_t;

  state_t        state_q, state_d;
  logic          next_q, autob_q;
  logic          pending_q, pending_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] sel_q, sel_d;
  logic          auto_q;
  logic [15:0]   fcnt_q;
  logic [11:0]   rgb_q;
  logic          de_q;

  logic frame_end;
  logic next_rise;
  logic auto_rise;
  logic auto_req;
  logic advance;
  logic blank;

  assign frame_end = DE && (x_pixel == X_LAST) && (y_pixel == Y_LAST);
  assign next_rise = btn_next & ~next_q;
  assign auto_rise = btn_auto & ~autob_q;
  assign auto_req  = auto_q && frame_end && (cnt_q == CNT_LAST);

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  // FSM next state: enter BLANK after an applied switch, leave at frame end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:   if (advance && (BLANK_EN != 0)) state_d = BLANK;
      BLANK: if (frame_end)                  state_d = RUN;
    endcase
  end

  // FSM outputs: blanking flag and the switch strobe taken only in RUN
  always_comb begin
    blank   = (state_q == BLANK);
    advance = (state_q == RUN) && frame_end && (pending_q || auto_req);
  end

  // Request latch, selection and auto-timer next state
  always_comb begin
    pending_d = pending_q;
    if (advance)        pending_d = next_rise;
    else if (next_rise) pending_d = 1'b1;

    sel_d = sel_q;
    if (advance) sel_d = (sel_q == SEL_LAST) ? '0 : sel_q + 1'b1;

    cnt_d = cnt_q;
    if (auto_rise || advance)    cnt_d = '0;
    else if (auto_q && frame_end)
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
  end

  // Control registers, frame counter and one-cycle RGB pipeline
  always_ff @(posedge clk) begin
    if (reset) begin
      next_q    <= 1'b1;
      autob_q   <= 1'b1;
      pending_q <= 1'b0;
      cnt_q     <= '0;
      sel_q     <= '0;
      auto_q    <= 1'b0;
      fcnt_q    <= '0;
      rgb_q     <= '0;
      de_q      <= 1'b0;
    end else begin
      next_q    <= btn_next;
      autob_q   <= btn_auto;
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
      sel_q     <= sel_d;
      auto_q    <= auto_q ^ auto_rise;
      fcnt_q    <= fcnt_q + {15'd0, frame_end};
      rgb_q     <= (!DE || blank) ? 12'h000
                                  : rgb_src_bus[12*sel_q +: 12];
      de_q      <= DE;
    end
  end

  assign {red_port, green_port, blue_port} = rgb_q;
  assign de_out      = de_q;
  assign pattern_sel = sel_q;
  assign auto_mode   = auto_q;
  assign frame_cnt   = fcnt_q;

endmodule

// File: tb/tb_vga_pattern_scheduler.sv
// Bench for vga_pattern_scheduler: small raster, directed scenarios,
// then random buttons/resets against a frame-level reference model.
module tb_vga_pattern_scheduler;

  localparam int H  = 8;
  localparam int V  = 4;
  localparam int HT = 10;
  localparam int VT = 6;
  localparam int NP = 4;
  localparam int AF = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  x_pixel, y_pixel;
  logic        DE, btn_next, btn_auto;
  logic [47:0] src_bus = {12'h444, 12'h333, 12'h222, 12'h111};
  logic [3:0]  red_port, green_port, blue_port;
  logic        de_out, auto_mode;
  logic [1:0]  pattern_sel;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  int xi = 0;
  int yi = 0;

  int          m_sel, m_pend, m_auto, m_acnt, m_fcnt;
  int          m_blank, m_pn, m_pa, m_de;
  logic [11:0] m_rgb;

  always #5 clk = ~clk;

  vga_pattern_scheduler #(
    .NUM_PATTERNS(NP), .AUTO_FRAMES(AF),
    .H_ACT(H), .V_ACT(V), .BLANK_EN(1)
  ) dut (
    .clk(clk), .reset(reset),
    .x_pixel(x_pixel), .y_pixel(y_pixel), .DE(DE),
    .btn_next(btn_next), .btn_auto(btn_auto),
    .rgb_src_bus(src_bus),
    .red_port(red_port), .green_port(green_port),
    .blue_port(blue_port), .de_out(de_out),
    .pattern_sel(pattern_sel), .auto_mode(auto_mode),
    .frame_cnt(frame_cnt)
  );

  function automatic logic [11:0] src(input int k);
    return 12'((k + 1) * 273);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    int fe, nr, ar, areq, adv;
    if (reset) begin
      m_sel = 0; m_pend = 0; m_auto = 0; m_acnt = 0; m_fcnt = 0;
      m_blank = 0; m_pn = 1; m_pa = 1; m_de = 0; m_rgb = 12'h000;
    end else begin
      fe = (DE && xi == H - 1 && yi == V - 1) ? 1 : 0;
      nr = (btn_next && m_pn == 0) ? 1 : 0;
      ar = (btn_auto && m_pa == 0) ? 1 : 0;
      m_rgb = (DE && m_blank == 0) ? src(m_sel) : 12'h000;
      m_de = DE ? 1 : 0;
      areq = (m_auto == 1 && fe == 1 && m_acnt == AF - 1) ? 1 : 0;
      adv = (m_blank == 0 && fe == 1 && (m_pend == 1 || areq == 1)) ? 1 : 0;
      if (fe == 1) m_fcnt = (m_fcnt + 1) % 65536;
      if (ar == 1 || adv == 1) m_acnt = 0;
      else if (m_auto == 1 && fe == 1) m_acnt = (m_acnt + 1) % AF;
      if (adv == 1) begin
        m_sel = (m_sel + 1) % NP;
        m_blank = 1;
        m_pend = nr;
      end else begin
        if (fe == 1) m_blank = 0;
        if (nr == 1) m_pend = 1;
      end
      if (ar == 1) m_auto = 1 - m_auto;
      m_pn = btn_next ? 1 : 0;
      m_pa = btn_auto ? 1 : 0;
    end
    @(posedge clk);
    #1;
    chk("rgb", 32'({red_port, green_port, blue_port}), 32'(m_rgb));
    chk("de_out", 32'(de_out), 32'(m_de));
    chk("sel", 32'(pattern_sel), 32'(m_sel));
    chk("auto", 32'(auto_mode), 32'(m_auto));
    chk("fcnt", 32'(frame_cnt), 32'(m_fcnt));
    xi++;
    if (xi == HT) begin
      xi = 0;
      yi = (yi + 1) % VT;
    end
    x_pixel = 10'(xi);
    y_pixel = 10'(yi);
    DE = (xi < H && yi < V);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // run to pixel (0,0) of the next frame and clock it through
  task automatic next_frame();
    for (int i = 0; i <= HT * VT && !(xi == 0 && yi == 0); i++) tick();
    tick();
  endtask

  initial begin
    x_pixel = 10'd0; y_pixel = 10'd0; DE = 1'b1;
    reset = 1'b1; btn_next = 1'b1; btn_auto = 1'b0;
    ticks(2);
    chk("rst_rgb", 32'({red_port, green_port, blue_port}), 32'h0);
    chk("rst_sel", 32'(pattern_sel), 32'h0);
    chk("rst_fcnt", 32'(frame_cnt), 32'h0);
    reset = 1'b0;
    ticks(3 * HT * VT);
    chk("held_sel", 32'(pattern_sel), 32'h0);
    next_frame();
    chk("held_rgb", 32'({red_port, green_port, blue_port}), 32'h111);

    btn_next = 1'b0; ticks(3);
    btn_next = 1'b1; ticks(3);
    btn_next = 1'b0;
    next_frame();
    chk("man_sel", 32'(pattern_sel), 32'h1);
    chk("man_blank", 32'({red_port, green_port, blue_port}), 32'h0);
    next_frame();
    chk("man_rgb", 32'({red_port, green_port, blue_port}), 32'h222);

    for (int p = 0; p < 3; p++) begin
      btn_next = 1'b1; ticks(2);
      btn_next = 1'b0; ticks(2);
    end
    next_frame();
    chk("multi_sel", 32'(pattern_sel), 32'h2);
    btn_next = 1'b1; ticks(2);
    btn_next = 1'b0; ticks(1);
    next_frame();
    chk("blkpress_hold", 32'(pattern_sel), 32'h2);
    chk("blkpress_rgb", 32'({red_port, green_port, blue_port}), 32'h333);
    next_frame();
    chk("blkpress_sel", 32'(pattern_sel), 32'h3);

    btn_auto = 1'b1; ticks(2);
    chk("auto_on", 32'(auto_mode), 32'h1);
    btn_auto = 1'b0;
    next_frame();
    chk("auto_w1", 32'(pattern_sel), 32'h3);
    next_frame();
    chk("auto_w2", 32'(pattern_sel), 32'h3);
    next_frame();
    chk("auto_wrap", 32'(pattern_sel), 32'h0);
    chk("auto_blank", 32'({red_port, green_port, blue_port}), 32'h0);
    next_frame();
    chk("auto_n1", 32'(pattern_sel), 32'h0);
    next_frame();
    chk("auto_n2", 32'(pattern_sel), 32'h0);
    next_frame();
    chk("auto_n3", 32'(pattern_sel), 32'h1);

    next_frame();
    next_frame();
    btn_next = 1'b1; ticks(2);
    btn_next = 1'b0;
    next_frame();
    chk("simul_sel", 32'(pattern_sel), 32'h2);
    next_frame();
    chk("simul_h1", 32'(pattern_sel), 32'h2);
    next_frame();
    chk("simul_h2", 32'(pattern_sel), 32'h2);
    next_frame();
    chk("simul_next", 32'(pattern_sel), 32'h3);

    btn_next = 1'b1; ticks(2);
    btn_next = 1'b0; ticks(1);
    reset = 1'b1; ticks(1);
    reset = 1'b0;
    chk("mrst_sel", 32'(pattern_sel), 32'h0);
    chk("mrst_auto", 32'(auto_mode), 32'h0);
    chk("mrst_fcnt", 32'(frame_cnt), 32'h0);
    chk("mrst_rgb", 32'({red_port, green_port, blue_port}), 32'h0);
    next_frame();
    next_frame();
    chk("mrst_noadv", 32'(pattern_sel), 32'h0);

    for (int c = 0; c < 40 * HT * VT; c++) begin
      if ($urandom % 40 == 0) btn_next = ~btn_next;
      if ($urandom % 90 == 0) btn_auto = ~btn_auto;
      reset = ($urandom % 1500 == 0);
      tick();
    end
    reset = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
